// File: rtl/mod_addsub_ctrl_if.sv
// mod_addsub_ctrl_if: request/response and mpadder bus of the modular add/sub
// controller.
//   slave  modport: the controller (takes requests, drives mpadder)
//   master modport: the environment (issues requests, hosts mpadder)
// Request side : start, subtract, in_a, in_b, in_m -> result, done, busy, error
// mpadder side : adder_start, adder_subtract, adder_in_a, adder_in_b
//                <- adder_result (WIDTH+1, MSB = carry-out), adder_done
`timescale 1ns/1ps
interface mod_addsub_ctrl_if #(
  parameter int unsigned WIDTH = 1027
);
  logic             start;
  logic             subtract;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             error;
  logic             adder_start;
  logic             adder_subtract;
  logic [WIDTH-1:0] adder_in_a;
  logic [WIDTH-1:0] adder_in_b;
  logic [WIDTH:0]   adder_result;
  logic             adder_done;

  modport slave (
    input  start, subtract, in_a, in_b, in_m, adder_result, adder_done,
    output result, done, busy, error,
           adder_start, adder_subtract, adder_in_a, adder_in_b
  );

  modport master (
    output start, subtract, in_a, in_b, in_m, adder_result, adder_done,
    input  result, done, busy, error,
           adder_start, adder_subtract, adder_in_a, adder_in_b
  );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// mod_addsub_ctrl: constant-time (A+B) mod M / (A-B) mod M controller on top
// of an external mpadder. Every request issues exactly two mpadder operations:
//   add: R1 = A+B, then R2 = R1-M; result = C2 ? R2 : R1
//   sub: R1 = A-B, then R2 = R1+M; result = C1 ? R1 : R2
// Ports: clk, reset (async, active-high), bus (mod_addsub_ctrl_if.slave).
// Latency start->done is 3 + 2*L for an mpadder latency of L cycles. A wait
// for adder_done longer than TIMEOUT cycles aborts with a sticky error.
`timescale 1ns/1ps
module mod_addsub_ctrl #(
  parameter int unsigned WIDTH   = 1027,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  mod_addsub_ctrl_if.slave bus
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP1_START,
    S_OP1_WAIT,
    S_OP2_START,
    S_OP2_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             sub_q;
  logic             mode_q;
  logic             c1_q;
  logic             error_q;
  logic             in_wait;
  logic             timed_out;

  assign in_wait   = (state_q == S_OP1_WAIT) || (state_q == S_OP2_WAIT);
  // adder_done on the boundary cycle wins over the timeout.
  assign timed_out = in_wait && !bus.adder_done && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.start) state_d = S_OP1_START;
      S_OP1_START: state_d = S_OP1_WAIT;
      S_OP1_WAIT:  if (bus.adder_done) state_d = S_OP2_START;
                   else if (timed_out) state_d = S_IDLE;
      S_OP2_START: state_d = S_OP2_WAIT;
      S_OP2_WAIT:  if (bus.adder_done) state_d = S_DONE;
                   else if (timed_out) state_d = S_IDLE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // a_q/b_q/mode_q drive the mpadder directly and only change on the
  // transitions into an op, so they stay stable through adder_done.
  // After op 1, a_q holds R1 for the rest of the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      m_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      sub_q    <= 1'b0;
      mode_q   <= 1'b0;
      c1_q     <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            m_q     <= bus.in_m;
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            sub_q   <= bus.subtract;
            mode_q  <= bus.subtract;
            error_q <= 1'b0;
          end
        end
        S_OP1_START, S_OP2_START: cnt_q <= '0;
        S_OP1_WAIT: begin
          if (bus.adder_done) begin
            a_q    <= bus.adder_result[WIDTH-1:0];
            c1_q   <= bus.adder_result[WIDTH];
            b_q    <= m_q;
            mode_q <= ~sub_q;
          end else if (timed_out) begin
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_OP2_WAIT: begin
          if (bus.adder_done) begin
            if (sub_q) result_q <= c1_q ? a_q : bus.adder_result[WIDTH-1:0];
            else       result_q <= bus.adder_result[WIDTH] ? bus.adder_result[WIDTH-1:0] : a_q;
          end else if (timed_out) begin
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.adder_start    = (state_q == S_OP1_START) || (state_q == S_OP2_START);
  assign bus.adder_subtract = mode_q;
  assign bus.adder_in_a     = a_q;
  assign bus.adder_in_b     = b_q;
  assign bus.result         = result_q;
  assign bus.done           = (state_q == S_DONE);
  assign bus.busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.error          = error_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// tb_mod_addsub_ctrl: directed and random checks of mod_addsub_ctrl against
// a plain-arithmetic modular reference, with a behavioural mpadder of
// programmable latency (or one that never answers).
`timescale 1ns/1ps
module tb_mod_addsub_ctrl;
  localparam int unsigned W = 1027;
  localparam int unsigned T = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mod_addsub_ctrl_if #(.WIDTH(W)) bus ();

  mod_addsub_ctrl #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // mpadder model and event counters
  int unsigned      lat_cfg = 1;
  bit               hang = 1'b0;
  int unsigned      rem = 0;
  int unsigned      n_astart = 0;
  int unsigned      n_done = 0;
  int unsigned      n_unstable = 0;
  logic [W-1:0]     cap_a, cap_b;
  logic             cap_s;

  function automatic logic [W:0] mpadd(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.adder_done   <= 1'b0;
      bus.adder_result <= '0;
      rem              <= 0;
    end else begin
      bus.adder_done <= 1'b0;
      if (bus.done) n_done <= n_done + 1;
      if (bus.adder_start) begin
        n_astart <= n_astart + 1;
        cap_a    <= bus.adder_in_a;
        cap_b    <= bus.adder_in_b;
        cap_s    <= bus.adder_subtract;
        if (hang) begin
          rem <= 0;
        end else if (lat_cfg == 1) begin
          rem              <= 0;
          bus.adder_done   <= 1'b1;
          bus.adder_result <= mpadd(bus.adder_in_a, bus.adder_in_b, bus.adder_subtract);
        end else begin
          rem <= lat_cfg - 1;
        end
      end else if (rem != 0) begin
        if (bus.adder_in_a !== cap_a || bus.adder_in_b !== cap_b || bus.adder_subtract !== cap_s)
          n_unstable <= n_unstable + 1;
        rem <= rem - 1;
        if (rem == 1) begin
          bus.adder_done   <= 1'b1;
          bus.adder_result <= mpadd(cap_a, cap_b, cap_s);
        end
      end
    end
  end

  // Reference: modular arithmetic straight from the definition.
  function automatic logic [W-1:0] ref_modop(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m, input logic sub);
    logic [W:0] s;
    if (!sub) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end else if (a >= b) begin
      s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, m} - {1'b0, b} + {1'b0, a};
    end
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_bits(input int unsigned nbits);
    logic [W-1:0] v;
    logic [W-1:0] mask;
    v = '0;
    repeat ((W + 31) / 32) v = (v << 32) | W'($urandom);
    mask = '1;
    mask = mask >> (W - nbits);
    return v & mask;
  endfunction

  task automatic chk_w(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (low 96 bits)", tag, got[95:0], exp[95:0]);
    end
  endtask

  task automatic chk_i(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk_w({tag, "_result"}, bus.result, '0);
    chk_w({tag, "_adder_in_a"}, bus.adder_in_a, '0);
    chk_w({tag, "_adder_in_b"}, bus.adder_in_b, '0);
    chk_i({tag, "_done"}, 32'(bus.done), 0);
    chk_i({tag, "_busy"}, 32'(bus.busy), 0);
    chk_i({tag, "_error"}, 32'(bus.error), 0);
    chk_i({tag, "_adder_start"}, 32'(bus.adder_start), 0);
    chk_i({tag, "_adder_subtract"}, 32'(bus.adder_subtract), 0);
  endtask

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] m, input logic sub);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_m     = m;
    bus.subtract = sub;
    bus.start    = 1'b1;
  endtask

  // One request with mpadder latency l; inj > 0 pulses a stray start with
  // other operands in that cycle. Returns observed start->done latency.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input logic sub, input int unsigned l,
                        input int unsigned inj, input logic [W-1:0] exp,
                        output int unsigned lat);
    int unsigned s0, d0, u0;
    s0 = n_astart;
    d0 = n_done;
    u0 = n_unstable;
    lat_cfg = l;
    drive_start(a, b, m, sub);
    @(negedge clk);
    bus.start = 1'b0;
    chk_i({tag, "_busy_c1"}, 32'(bus.busy), 1);
    chk_i({tag, "_error_c1"}, 32'(bus.error), 0);
    lat = 0;
    for (int unsigned c = 2; c <= 3 + 2 * l + 4 && lat == 0; c++) begin
      @(negedge clk);
      if (c == inj) drive_start(~a, ~b, m >> 1, ~sub);
      else bus.start = 1'b0;
      if (bus.done) lat = c;
    end
    bus.start = 1'b0;
    chk_i({tag, "_latency"}, lat, 3 + 2 * l);
    chk_w({tag, "_result"}, bus.result, exp);
    chk_i({tag, "_busy_at_done"}, 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    chk_i({tag, "_done_count"}, n_done - d0, 1);
    chk_i({tag, "_adder_starts"}, n_astart - s0, 2);
    chk_i({tag, "_operands_stable"}, n_unstable - u0, 0);
    chk_w({tag, "_result_held"}, bus.result, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat, lat1, lat2, s0, d0;
    logic [W-1:0] prev, a, b, m, one;
    logic sub;
    int unsigned l;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.subtract = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_m = '0;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset_held");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_zero("after_reset");

    run_op("add_nowrap", W'(5), W'(7), W'(13), 1'b0, 2, 0, W'(12), lat);
    run_op("add_wrap", W'(9), W'(7), W'(13), 1'b0, 3, 0, W'(3), lat);
    run_op("sub_neg", W'(3), W'(9), W'(13), 1'b1, 2, 0, W'(7), lat1);
    run_op("sub_zero", W'(5), W'(5), W'(13), 1'b1, 2, 0, W'(0), lat2);
    chk_i("sub_same_latency", lat1, lat2);
    run_op("busy_start", W'(9), W'(7), W'(13), 1'b0, 3, 3, W'(3), lat);

    // mpadder never answers
    prev = bus.result;
    s0 = n_astart;
    d0 = n_done;
    hang = 1'b1;
    drive_start(W'(1), W'(2), W'(13), 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int unsigned c = 2; c <= T + 1; c++) @(negedge clk);
    chk_i("timeout_error_before", 32'(bus.error), 0);
    chk_i("timeout_busy_before", 32'(bus.busy), 1);
    @(negedge clk);
    chk_i("timeout_error", 32'(bus.error), 1);
    chk_i("timeout_busy", 32'(bus.busy), 0);
    chk_i("timeout_done", 32'(bus.done), 0);
    chk_w("timeout_result_kept", bus.result, prev);
    repeat (3) @(negedge clk);
    chk_i("timeout_error_sticky", 32'(bus.error), 1);
    chk_i("timeout_no_done", n_done - d0, 0);
    chk_i("timeout_one_start", n_astart - s0, 1);
    hang = 1'b0;
    run_op("after_timeout", W'(4), W'(11), W'(13), 1'b0, 1, 0, W'(2), lat);
    run_op("boundary_latency", W'(12), W'(1), W'(13), 1'b0, T, 0, W'(0), lat);
    chk_i("boundary_no_error", 32'(bus.error), 0);

    // reset during OP2_WAIT (L=3: OP2_WAIT starts in cycle 6)
    d0 = n_done;
    lat_cfg = 3;
    drive_start(W'(9), W'(7), W'(13), 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk_i("pre_reset_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    chk_idle_zero("midop_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk_i("midop_reset_no_done", n_done - d0, 0);
    chk_i("midop_reset_idle", 32'(bus.busy), 0);
    run_op("post_reset_add", W'(1), W'(1), W'(13), 1'b0, 2, 0, W'(2), lat);

    // wide operands, boundary and random
    one = W'(1);
    m = rand_bits(1024) | (one << 1024);
    run_op("wide_add_max", m - one, m - one, m, 1'b0, 2, 0, m - W'(2), lat);
    run_op("wide_sub_min", W'(0), m - one, m, 1'b1, 1, 0, W'(1), lat);
    for (int i = 0; i < 16; i++) begin
      m = rand_bits(1024) | (one << 1024);
      a = rand_bits(1024);
      b = rand_bits(1024);
      sub = 1'($urandom_range(0, 1));
      l = $urandom_range(1, 4);
      run_op($sformatf("rand%0d", i), a, b, m, sub, l, 0, ref_modop(a, b, m, sub), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
